// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the clock divider bank.
// The config struct pairs a period (divisor) with the high time of each period.
package clkdiv_pkg;

    localparam int CLKDIV_WIDTH    = 32;
    localparam int CLKDIV_CHANNELS = 4;

    typedef struct packed {
        logic [CLKDIV_WIDTH-1:0] divisor;
        logic [CLKDIV_WIDTH-1:0] high;
    } clkdiv_cfg_t;

    localparam logic OUT_RESET     = 1'b0;
    localparam logic PENDING_RESET = 1'b0;

endpackage

// File: rtl/divider_channel.sv
// One divider channel: period counter, active/shadow config with period-boundary
// update, and registered divided-clock and period-start outputs.
module divider_channel
    import clkdiv_pkg::*;
#(
    parameter int  WIDTH = CLKDIV_WIDTH,
    parameter type cfg_t = clkdiv_cfg_t
) (
    input  logic clock_in,
    input  logic reset,
    input  logic enable,
    input  logic sync,
    input  logic wr,
    input  cfg_t wr_cfg,
    output logic clock_out,
    output logic tick,
    output logic pending
);

    cfg_t             active, active_next;
    cfg_t             shadow, shadow_next;
    logic [WIDTH-1:0] count, count_next;
    logic             pending_next;
    logic             enable_q;
    logic             running, at_wrap, run_next;
    logic             clock_out_next, tick_next;

    // enable_q delays counting by one cycle so the first enabled cycle shows c=0 low
    // and the next shows c=0 with the tick.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        active_next  = active;
        shadow_next  = shadow;
        pending_next = pending;
        count_next   = count;

        running = enable_q && enable && (active.divisor != '0);
        at_wrap = running && (count == active.divisor - WIDTH'(1));

        if (sync) begin
            count_next = '0;
            if (wr) begin
                active_next  = wr_cfg;
                shadow_next  = wr_cfg;
                pending_next = 1'b0;
            end else if (pending) begin
                active_next  = shadow;
                pending_next = 1'b0;
            end
        end else begin
            count_next = (running && !at_wrap) ? count + WIDTH'(1) : '0;
            if (pending && (!running || at_wrap)) begin
                active_next  = shadow;
                pending_next = 1'b0;
            end
            // A write landing on the apply edge becomes the next pending config.
            if (wr) begin
                shadow_next  = wr_cfg;
                pending_next = 1'b1;
            end
        end

        run_next       = enable && (active_next.divisor != '0);
        clock_out_next = run_next && (count_next < active_next.high);
        tick_next      = run_next && (count_next == '0);
    end

    always_ff @(posedge clock_in) begin
        // NOTE: state flops use non-blocking assignments so all channels update from the same pre-edge values.
        if (reset) begin
            active    <= '0;
            shadow    <= '0;
            count     <= '0;
            pending   <= PENDING_RESET;
            enable_q  <= 1'b0;
            clock_out <= OUT_RESET;
            tick      <= OUT_RESET;
        end else begin
            active    <= active_next;
            shadow    <= shadow_next;
            count     <= count_next;
            pending   <= pending_next;
            enable_q  <= enable;
            clock_out <= clock_out_next;
            tick      <= tick_next;
        end
    end

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock divider with double-buffered per-channel config
// and a global phase-realigning sync.
module clock_divider_bank
    import clkdiv_pkg::*;
#(
    parameter  int CHANNELS = CLKDIV_CHANNELS,
    parameter  int WIDTH    = CLKDIV_WIDTH,
    localparam int CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock_in,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                sync,
    input  logic                cfg_write,
    input  logic [CH_BITS-1:0]  cfg_channel,
    input  logic [WIDTH-1:0]    cfg_divisor,
    input  logic [WIDTH-1:0]    cfg_high,
    output logic [CHANNELS-1:0] clock_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);

    typedef struct packed {
        logic [WIDTH-1:0] divisor;
        logic [WIDTH-1:0] high;
    } bank_cfg_t;

    bank_cfg_t           wr_cfg;
    logic [CHANNELS-1:0] wr;

    assign wr_cfg = '{divisor: cfg_divisor, high: cfg_high};

    // Out-of-range channel numbers match no index, so such writes are dropped.
    always_comb begin
        wr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            wr[i] = cfg_write && (cfg_channel == CH_BITS'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
        divider_channel #(
            .WIDTH (WIDTH),
            .cfg_t (bank_cfg_t)
        ) u_channel (
            .clock_in  (clock_in),
            .reset     (reset),
            .enable    (enable[g]),
            .sync      (sync),
            .wr        (wr[g]),
            .wr_cfg    (wr_cfg),
            .clock_out (clock_out[g]),
            .tick      (tick[g]),
            .pending   (pending[g])
        );
    end

endmodule
